// File: rtl/mmio_out_bank.sv
// Memory-mapped output bank: CHANNELS ports of WIDTH bits, each in direct, blink or PWM mode.
// Define MMIO_READBACK_EN to build the register readback mux on d_out; otherwise d_out is tied to 0.
module mmio_out_bank #(
    parameter int          CHANNELS  = 2,
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_FF00,
    parameter int          CNT_BITS  = 24,
    parameter int          PWM_BITS  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic [31:0]               addr,
    input  logic [31:0]               d_in,
    output logic                      hit,
    output logic [31:0]               d_out,
    output logic [CHANNELS*WIDTH-1:0] out
);

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_PWM    = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    logic [3:0] sel_ch;
    logic [1:0] sel_reg;
    logic       unused_byte_lane;

    assign sel_ch           = addr[7:4];
    assign sel_reg          = addr[3:2];
    assign unused_byte_lane = ^addr[1:0];
    assign hit              = (addr[31:8] == BASE_ADDR[31:8]) && (int'(sel_ch) < CHANNELS);

`ifdef MMIO_READBACK_EN
    logic [31:0] rd_data  [CHANNELS];
    logic [31:0] rd_mode  [CHANNELS];
    logic [31:0] rd_param [CHANNELS];
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0]    data_q;
        mode_e               mode_q;
        logic [CNT_BITS-1:0] param_q;
        logic [CNT_BITS-1:0] bcnt_q;
        logic                phase_q;
        logic [PWM_BITS-1:0] pcnt_q;
        logic [WIDTH-1:0]    out_q;
        logic [WIDTH-1:0]    out_d;
        logic                wr;

        assign wr = we && hit && (sel_ch == 4'(c));

        // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
        always_comb begin
            out_d = data_q;
            case (mode_q)
                MODE_BLINK: if (param_q != '0 && !phase_q) out_d = '0;
                MODE_PWM:   if (!(pcnt_q < param_q[PWM_BITS-1:0])) out_d = '0;
                default:    out_d = data_q;
            endcase
        end

        // NOTE: state uses non-blocking assignments; every register, out_q included, is cleared
        // by the async reset so the pins drop to 0 without waiting for a clock edge.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                data_q  <= '0;
                mode_q  <= MODE_DIRECT;
                param_q <= '0;
                bcnt_q  <= '0;
                phase_q <= 1'b1;
                pcnt_q  <= '0;
                out_q   <= '0;
            end else begin
                out_q  <= out_d;
                pcnt_q <= pcnt_q + 1'b1;
                // >= keeps the counter from running past a PARAM that was lowered mid-count
                if (mode_q == MODE_BLINK && param_q != '0) begin
                    if (bcnt_q >= param_q) begin
                        bcnt_q  <= '0;
                        phase_q <= ~phase_q;
                    end else begin
                        bcnt_q <= bcnt_q + 1'b1;
                    end
                end
                if (wr) begin
                    case (sel_reg)
                        2'd0: data_q <= d_in[WIDTH-1:0];
                        2'd1: begin
                            mode_q  <= mode_e'(d_in[1:0]);
                            bcnt_q  <= '0;
                            pcnt_q  <= '0;
                            phase_q <= 1'b1;
                        end
                        2'd2: begin
                            param_q <= d_in[CNT_BITS-1:0];
                            bcnt_q  <= '0;
                            pcnt_q  <= '0;
                            phase_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign out[c*WIDTH +: WIDTH] = out_q;

`ifdef MMIO_READBACK_EN
        assign rd_data[c]  = 32'(data_q);
        assign rd_mode[c]  = {30'd0, mode_q};
        assign rd_param[c] = 32'(param_q);
`endif
    end

`ifdef MMIO_READBACK_EN
    always_comb begin
        d_out = '0;
        if (hit) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel_ch == 4'(i)) begin
                    case (sel_reg)
                        2'd0:    d_out = rd_data[i];
                        2'd1:    d_out = rd_mode[i];
                        2'd2:    d_out = rd_param[i];
                        default: d_out = '0;
                    endcase
                end
            end
        end
    end
`else
    assign d_out = '0;
`endif

endmodule

// File: tb/tb_mmio_out_bank.sv
// Self-checking bench for mmio_out_bank: decode table, scoreboard of expected outputs, mode sequences.
module tb_mmio_out_bank;

    localparam logic [31:0] BASE = 32'h0000_FF00;
`ifdef MMIO_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        we;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic        hit;
    logic [31:0] d_out;
    logic [63:0] out;

    mmio_out_bank #(
        .CHANNELS (2),
        .WIDTH    (32),
        .BASE_ADDR(BASE),
        .CNT_BITS (24),
        .PWM_BITS (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .we   (we),
        .addr (addr),
        .d_in (d_in),
        .hit  (hit),
        .d_out(d_out),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard: expected value of out after a given edge, compared on the following falling edge.
    typedef struct {
        int          due;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    task automatic expect_out(input int delay, input logic [63:0] v, input string name);
        sb_q.push_back('{cyc + delay, v, name});
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            check(mon_e.name, out, mon_e.exp);
        end
    end

    task automatic drain();
        int n = 0;
        while (sb_q.size() > 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() > 0) begin
            check("scoreboard_drain", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // One bus write; returns 1 time unit after the edge that samples it.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        d_in = d;
        @(posedge clk);
        #1;
        we   = 1'b0;
        addr = '0;
        d_in = '0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] v);
        addr = a;
        #1;
        check(name, 64'(d_out), RB ? 64'(v) : 64'd0);
        addr = '0;
    endtask

    // Skips the cycle still showing pre-write state, then counts high cycles of out[0] over 256 cycles.
    task automatic count_high(output int n);
        n = 0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            n += int'(out[0]);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic        exp_hit;
        logic [31:0] exp_rd;
    } dec_t;

    dec_t dec_tab[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;

        dec_tab[0] = '{BASE + 32'h00, 1'b1, 32'h0};
        dec_tab[1] = '{BASE + 32'h0C, 1'b1, 32'h0};
        dec_tab[2] = '{BASE + 32'h13, 1'b1, 32'hDEAD_BEEF};
        dec_tab[3] = '{BASE + 32'h1C, 1'b1, 32'h0};
        dec_tab[4] = '{BASE + 32'h20, 1'b0, 32'h0};
        dec_tab[5] = '{BASE + 32'hF0, 1'b0, 32'h0};
        dec_tab[6] = '{32'h0000_FE10, 1'b0, 32'h0};
        dec_tab[7] = '{32'h0100_FF10, 1'b0, 32'h0};

        reset = 1'b0;
        we    = 1'b0;
        addr  = '0;
        d_in  = '0;

        // Reset held with random bus traffic
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            we   = 1'($urandom_range(0, 1));
            addr = {16'h0000, 8'hFF, 8'($urandom)};
            d_in = $urandom;
            @(negedge clk);
            check("reset_out", out, 64'd0);
            check("reset_dout", 64'(d_out), 64'd0);
        end
        @(posedge clk);
        #1;
        we    = 1'b0;
        addr  = '0;
        d_in  = '0;
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) expect_out(k, 64'd0, "idle_after_reset");
        drain();

        // Direct write to channel 1
        bus_write(BASE + 32'h10, 32'hDEAD_BEEF);
        expect_out(1, {32'hDEAD_BEEF, 32'h0}, "direct_ch1");
        expect_out(3, {32'hDEAD_BEEF, 32'h0}, "direct_ch1_hold");
        read_check("readback_ch1_data", BASE + 32'h10, 32'hDEAD_BEEF);
        drain();

        // Decode table
        for (int i = 0; i < 8; i++) begin
            addr = dec_tab[i].a;
            #1;
            check($sformatf("decode_hit_%0d", i), 64'(hit), 64'(dec_tab[i].exp_hit));
            check($sformatf("decode_dout_%0d", i), 64'(d_out), RB ? 64'(dec_tab[i].exp_rd) : 64'd0);
        end
        addr = '0;

        // Writes outside the window or to the reserved slot change nothing
        we = 1'b1; addr = BASE + 32'h20; d_in = 32'h1234_5678;
        #1;
        check("wr_hit_past_channels", 64'(hit), 64'd0);
        @(posedge clk);
        #1;
        addr = BASE + 32'h0C; d_in = 32'hFFFF_FFFF;
        #1;
        check("wr_hit_reserved", 64'(hit), 64'd1);
        @(posedge clk);
        #1;
        addr = 32'h0000_FE00; d_in = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        we = 1'b0; addr = '0; d_in = '0;
        for (int k = 1; k <= 3; k++) expect_out(k, {32'hDEAD_BEEF, 32'h0}, "no_effect_writes");
        read_check("readback_ch0_data", BASE + 32'h00, 32'h0);
        read_check("readback_ch0_mode", BASE + 32'h04, 32'h0);
        read_check("readback_ch0_param", BASE + 32'h08, 32'h0);
        drain();

        // Blink: PARAM=3 gives 4-cycle phases, starting in the DATA phase
        bus_write(BASE + 32'h00, 32'h0000_00A5);
        bus_write(BASE + 32'h08, 32'd3);
        bus_write(BASE + 32'h04, 32'd1);
        for (int k = 1; k <= 12; k++)
            expect_out(k, {32'hDEAD_BEEF, 24'h0, (((k - 1) / 4) % 2 == 0) ? 8'hA5 : 8'h00}, "blink");
        drain();
        read_check("readback_ch0_mode_blink", BASE + 32'h04, 32'd1);
        bus_write(BASE + 32'h08, 32'd0);
        for (int k = 1; k <= 6; k++) expect_out(k, {32'hDEAD_BEEF, 32'h0000_00A5}, "blink_param0_steady");
        drain();

        // PWM duty sweep
        bus_write(BASE + 32'h00, 32'd1);
        bus_write(BASE + 32'h08, 32'd64);
        bus_write(BASE + 32'h04, 32'd2);
        count_high(hi);
        check("pwm_duty64_high", 64'(hi), 64'd64);
        check("pwm_ch1_untouched", {out[63:32], 32'h0}, {32'hDEAD_BEEF, 32'h0});
        @(posedge clk);
        #1;
        bus_write(BASE + 32'h08, 32'd0);
        count_high(hi);
        check("pwm_duty0_high", 64'(hi), 64'd0);
        @(posedge clk);
        #1;
        bus_write(BASE + 32'h08, 32'd255);
        count_high(hi);
        check("pwm_duty255_high", 64'(hi), 64'd255);
        @(posedge clk);
        #1;

        // Async reset in the middle of a blink phase
        bus_write(BASE + 32'h00, 32'h0000_00A5);
        bus_write(BASE + 32'h08, 32'd3);
        bus_write(BASE + 32'h04, 32'd1);
        @(posedge clk);
        #3;
        check("pre_reset_blink_on", 64'(out[7:0]), 64'hA5);
        reset = 1'b0;
        #1;
        check("async_reset_immediate", out, 64'd0);
        read_check("async_reset_mode_rd", BASE + 32'h04, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) expect_out(k, 64'd0, "post_reset_idle");
        drain();
        bus_write(BASE + 32'h08, 32'd3);
        bus_write(BASE + 32'h00, 32'h0000_003C);
        for (int k = 1; k <= 8; k++) expect_out(k, {32'h0, 32'h0000_003C}, "post_reset_direct");
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
